piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_bit_cnt.sv | 31 +++
 rtl/piso_serializer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in / serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter width: ceil(log2(n+2)), which covers a frame of n data bits plus parity.
  function automatic int cnt_width(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Frame bit counter: synchronous clear, enable, and a terminal-count flag.
// The counter stops at LAST, so it never runs past the final frame bit.
module piso_bit_cnt #(
  parameter int W    = 4,
  parameter int LAST = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [W-1:0] LAST_C = W'(LAST);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == LAST_C);

endmodule

// File: rtl/piso_serializer.sv
// PISO serializer with a one-deep holding buffer for back-to-back frames.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         tick,
  output logic         q,
  output logic         q_valid,
  output logic         done
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif
  localparam int CW = cnt_width(N);

  state_t         state, state_nx;
  logic [F-1:0]   frame;
  logic [F-1:0]   frame_shifted;
  logic [N-1:0]   buf_data;
  logic           buf_full;
  logic [N-1:0]   load_word;
  logic           load_frame;
  logic           cnt_last;
  logic           cnt_clr;
  logic           cnt_en;
  logic           head;
  logic           xfer;
  logic           last_tick;

  // The head bit always sits at the end the frame shifts out of; parity is placed last in line.
  function automatic logic [F-1:0] build_frame(input logic [N-1:0] w);
`ifdef PISO_SERIALIZER_PARITY_EN
    return (MSB_FIRST != 0) ? {w, ^w} : {^w, w};
`else
    return w;
`endif
  endfunction

  assign head          = (MSB_FIRST != 0) ? frame[F-1] : frame[0];
  assign frame_shifted = (MSB_FIRST != 0) ? {frame[F-2:0], 1'b0} : {1'b0, frame[F-1:1]};
  assign xfer          = load_valid && load_ready;
  assign last_tick     = (state == SHIFT) && tick && cnt_last;
  assign cnt_clr       = load_frame || last_tick;
  assign cnt_en        = (state == SHIFT) && tick && !cnt_last;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // NOTE: every variable gets a default first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    load_frame = 1'b0;
    load_word  = d;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nx   = SHIFT;
          load_frame = 1'b1;
        end
      end
      SHIFT: begin
        if (last_tick) begin
          if (buf_full) begin
            load_frame = 1'b1;
            load_word  = buf_data;
          end else if (xfer) begin
            load_frame = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b1;
    q          = 1'b0;
    q_valid    = 1'b0;
    done       = 1'b0;
    if (state == SHIFT) begin
      load_ready = !buf_full;
      q          = head;
      q_valid    = 1'b1;
      done       = last_tick;
    end
  end

  // NOTE: frame and buffer data are reset along with the control flops, so nothing stale leaks after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame    <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
    end else begin
      if (load_frame)                     frame <= build_frame(load_word);
      else if (state == SHIFT && tick)    frame <= frame_shifted;

      // A word arriving on the last-bit tick bypasses the buffer and goes straight into the frame.
      if (xfer && state == SHIFT && !last_tick) begin
        buf_data <= d;
        buf_full <= 1'b1;
      end else if (last_tick && buf_full) begin
        buf_full <= 1'b0;
      end
    end
  end

  piso_bit_cnt #(
    .W    (CW),
    .LAST (F - 1)
  ) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

endmodule
